bus_req_arbiter: RTL

Round-robin arbiter and sequencer for a shared 32-bit req/gnt bus with NUM_REQ requesters. It picks one requester and registers that requester's data onto the bus. The data is held stable for HOLD_CYC cycles, then a one-cycle grant is issued and the bus is driven to zero. The bus protocol (data stable from request until grant, bus zeroed after grant, request held until grant) is enforced by construction and flagged when a requester breaks it.

---
 rtl/bus_arb_pkg.sv | 15 +
 rtl/bus_arb_rr_pick.sv | 28 ++
 rtl/bus_req_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and widths for the bus request arbiter.
package bus_arb_pkg;

  localparam int BUS_DATA_W = 32;
  localparam int HOLD_CNT_W = 3;
  localparam int STAT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    GRANT = 2'd2,
    CLEAR = 2'd3
  } state_t;

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Combinational round-robin picker: first set request after ptr_i, wrapping.
module bus_arb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  int cand;

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = (int'(ptr_i) + off) % NUM_REQ;
      if (req_i[cand[IDX_W-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_req_arbiter.sv
// Round-robin req/gnt bus arbiter: captures the winner's data onto a
// registered bus, holds it HOLD_CYC cycles, pulses a grant, then zeroes
// the bus. Optional statistics counters are built when BUS_ARB_STATS_EN
// is defined.
//
// state | meaning
// IDLE  | bus zero, arbitrating among requests every cycle
// HOLD  | owner data on bus, counting down the hold time
// GRANT | one-cycle grant pulse to owner, bus still valid
// CLEAR | bus zeroed, pointer advanced to owner, requests ignored
module bus_req_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = BUS_DATA_W,
  parameter int HOLD_CYC = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ*DATA_W-1:0]   data_i,
  output logic [NUM_REQ-1:0]          gnt_o,
  output logic [DATA_W-1:0]           bus_o,
  output logic                        bus_valid_o,
  output logic [$clog2(NUM_REQ)-1:0]  owner_o,
  output logic                        err_drop_o,
  output logic                        err_unstable_o
`ifdef BUS_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_CNT_W-1:0] grant_cnt_o,
  output logic [STAT_CNT_W-1:0]         err_cnt_o
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t                state_q, state_d;
  logic [HOLD_CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [DATA_W-1:0]     bus_q, bus_d;

  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_idx;
  logic [DATA_W-1:0]     pick_data;
  logic [DATA_W-1:0]     owner_data;

  bus_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign pick_data  = data_i[int'(pick_idx)*DATA_W +: DATA_W];
  assign owner_data = data_i[int'(owner_q)*DATA_W +: DATA_W];

  // State, counter, owner, pointer and bus registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= IDX_W'(NUM_REQ-1);
      bus_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      bus_q   <= bus_d;
    end
  end

  // Next-state logic plus protocol checks on the current owner.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    owner_d        = owner_q;
    ptr_d          = ptr_q;
    bus_d          = bus_q;
    err_drop_o     = 1'b0;
    err_unstable_o = 1'b0;
    case (state_q)
      IDLE: begin
        bus_d = '0;
        if (pick_valid) begin
          owner_d = pick_idx;
          bus_d   = pick_data;
          cnt_d   = HOLD_CNT_W'(HOLD_CYC-1);
          state_d = HOLD;
        end
      end
      HOLD: begin
        err_unstable_o = (owner_data != bus_q);
        if (!req_i[owner_q]) begin
          // Owner abandoned its request: skip the grant entirely.
          err_drop_o = 1'b1;
          bus_d      = '0;
          state_d    = CLEAR;
        end else if (cnt_q == '0) begin
          state_d = GRANT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GRANT: begin
        err_unstable_o = (owner_data != bus_q);
        bus_d          = '0;
        state_d        = CLEAR;
      end
      CLEAR: begin
        ptr_d   = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state.
  always_comb begin
    gnt_o = '0;
    if (state_q == GRANT) gnt_o[owner_q] = 1'b1;
    bus_o       = bus_q;
    bus_valid_o = (state_q == HOLD) || (state_q == GRANT);
    owner_o     = owner_q;
  end

`ifdef BUS_ARB_STATS_EN
  logic [STAT_CNT_W-1:0] gcnt_q [NUM_REQ];
  logic [STAT_CNT_W-1:0] ecnt_q;

  // Saturating grant and error counters; a cycle with both errors counts once.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) gcnt_q[i] <= '0;
      ecnt_q <= '0;
    end else begin
      if (state_q == GRANT && gcnt_q[owner_q] != '1)
        gcnt_q[owner_q] <= gcnt_q[owner_q] + 1'b1;
      if ((err_drop_o || err_unstable_o) && ecnt_q != '1)
        ecnt_q <= ecnt_q + 1'b1;
    end
  end

  // Flatten per-requester counters onto the output vector.
  always_comb begin
    grant_cnt_o = '0;
    for (int i = 0; i < NUM_REQ; i++)
      grant_cnt_o[i*STAT_CNT_W +: STAT_CNT_W] = gcnt_q[i];
    err_cnt_o = ecnt_q;
  end
`endif

endmodule
